// File: rtl/lab4_tx_scheduler.sv
// Round-robin scheduler that shares one serial transmitter between N_REQ
// requesters. It grants one pending requester, registers its word onto D,
// pulses baslat, follows mesgul through one transfer and then acks the
// requester. If mesgul never rises it errors the transfer after TIMEOUT cycles.
module lab4_tx_scheduler #(
    parameter int N_REQ   = 4,
    parameter int DW      = 5,
    parameter int TIMEOUT = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                en,
    input  logic [N_REQ-1:0]    req,
    input  logic [N_REQ*DW-1:0] data_in,
    output logic [N_REQ-1:0]    ack,
    output logic                err,
    output logic [2:0]          gnt_id,
    output logic                active,
    output logic                baslat,
    output logic [DW-1:0]       D,
    input  logic                mesgul
);

    localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        WAIT_BUSY,
        WAIT_DONE,
        ACK_S
    } state_t;

    state_t             state_q, state_d;
    logic [PW-1:0]      ptr_q, ptr_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [2:0]         gnt_d;
    logic [DW-1:0]      word_d;
    logic               active_d, baslat_d, err_d;
    logic [N_REQ-1:0]   ack_d;
    logic [N_REQ-1:0]   ack_onehot;
    logic               found;
    logic [2:0]         pick;

    // Round-robin search: first set request scanning up from ptr, wrapping.
    // NOTE: every signal written in an always_comb gets a default first, so
    // no path leaves it unassigned and no latch is inferred.
    always_comb begin
        found = 1'b0;
        pick  = '0;
        for (int k = 0; k < N_REQ; k++) begin
            if (!found && req[(int'(ptr_q) + k) % N_REQ]) begin
                found = 1'b1;
                pick  = 3'((int'(ptr_q) + k) % N_REQ);
            end
        end
    end

    // One-hot ack pattern for the requester currently being served.
    always_comb begin
        ack_onehot = {{(N_REQ-1){1'b0}}, 1'b1} << gnt_id;
    end

    // Next-state logic. All outputs are produced as next values and then
    // registered, so baslat/ack/err come straight from flops and cannot glitch.
    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        cnt_d    = cnt_q;
        gnt_d    = gnt_id;
        word_d   = D;
        active_d = active;
        baslat_d = 1'b0;
        ack_d    = '0;
        err_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (en && found) begin
                    gnt_d    = pick;
                    word_d   = data_in[int'(pick)*DW +: DW];
                    active_d = 1'b1;
                    baslat_d = 1'b1;
                    state_d  = START;
                end
            end
            START: begin
                cnt_d   = '0;
                state_d = WAIT_BUSY;
            end
            WAIT_BUSY: begin
                if (mesgul) begin
                    state_d = WAIT_DONE;
                end else if (cnt_q == CW'(TIMEOUT)) begin
                    ack_d   = ack_onehot;
                    err_d   = 1'b1;
                    state_d = ACK_S;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            WAIT_DONE: begin
                if (!mesgul) begin
                    ack_d   = ack_onehot;
                    state_d = ACK_S;
                end
            end
            ACK_S: begin
                // Advance past the served requester so it cannot jump the queue.
                ptr_d    = PW'((int'(gnt_id) + 1) % N_REQ);
                active_d = 1'b0;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and output registers; reset returns to IDLE with all outputs low.
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            cnt_q   <= '0;
            gnt_id  <= '0;
            D       <= '0;
            active  <= 1'b0;
            baslat  <= 1'b0;
            ack     <= '0;
            err     <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            gnt_id  <= gnt_d;
            D       <= word_d;
            active  <= active_d;
            baslat  <= baslat_d;
            ack     <= ack_d;
            err     <= err_d;
        end
    end

endmodule

// File: tb/tb_lab4_tx_scheduler.sv
// Self-checking bench for lab4_tx_scheduler: directed scenarios followed by
// randomized transfers, checked against a round-robin reference model.
module tb_lab4_tx_scheduler;

    localparam int N  = 4;
    localparam int DW = 5;
    localparam int TO = 8;

    logic            clk = 1'b0;
    logic            reset;
    logic            en;
    logic [N-1:0]    req;
    logic [N*DW-1:0] data_in;
    logic [N-1:0]    ack;
    logic            err;
    logic [2:0]      gnt_id;
    logic            active;
    logic            baslat;
    logic [DW-1:0]   D;
    logic            mesgul;

    int passed = 0;
    int total  = 0;
    int mptr   = 0;   // model round-robin pointer
    int got;
    int order [5];

    lab4_tx_scheduler #(.N_REQ(N), .DW(DW), .TIMEOUT(TO)) dut (
        .clk     (clk),
        .reset   (reset),
        .en      (en),
        .req     (req),
        .data_in (data_in),
        .ack     (ack),
        .err     (err),
        .gnt_id  (gnt_id),
        .active  (active),
        .baslat  (baslat),
        .D       (D),
        .mesgul  (mesgul)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: observed no end, required finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Reference arbiter: first set request at or after p, wrapping modulo N.
    function automatic int model_pick(input logic [N-1:0] r, input int p);
        for (int k = 0; k < N; k++)
            if (r[(p + k) % N]) return (p + k) % N;
        return -1;
    endfunction

    function automatic logic [DW-1:0] word_of(input int i);
        return data_in[i*DW +: DW];
    endfunction

    // One full transfer starting from IDLE with req/data already applied.
    // rd: cycles before mesgul rises, bl: cycles mesgul stays high,
    // tmo: mesgul never rises, clr: served requester drops req,
    // en_drop: en falls right after the grant.
    task automatic run_transfer(input int rd, input int bl, input bit tmo,
                                input bit clr, input bit en_drop, output int gid);
        int            exp_id;
        logic [DW-1:0] exp_word;
        logic [N-1:0]  exp_ack;
        exp_id   = model_pick(req, mptr);
        exp_word = word_of(exp_id);
        exp_ack  = N'(1) << exp_id;
        tick;
        gid = int'(gnt_id);
        check("grant_active", active, 1);
        check("grant_baslat", baslat, 1);
        check("grant_id", gnt_id, exp_id);
        check("grant_word", D, exp_word);
        if (en_drop) en = 1'b0;
        if (tmo) begin
            mesgul = 1'b0;
            for (int i = 1; i <= TO + 1; i++) begin
                tick;
                check("tmo_no_early_ack", ack, 0);
                check("tmo_baslat_low", baslat, 0);
                if ($urandom_range(2) == 0) data_in = N*DW'($urandom);
            end
            tick;
            check("tmo_ack", ack, exp_ack);
            check("tmo_err", err, 1);
        end else begin
            for (int i = 0; i < rd + bl; i++) begin
                if (i == rd) mesgul = 1'b1;
                tick;
                check("wait_no_ack", ack, 0);
                check("wait_baslat_low", baslat, 0);
                if ($urandom_range(2) == 0) data_in = N*DW'($urandom);
                if (clr && $urandom_range(3) == 0) req[exp_id] = 1'b0;
            end
            mesgul = 1'b0;
            tick;
            check("done_ack", ack, exp_ack);
            check("done_err", err, 0);
        end
        check("ack_active", active, 1);
        check("stable_id", gnt_id, exp_id);
        check("stable_word", D, exp_word);
        if (clr) req[exp_id] = 1'b0;
        mptr = (exp_id + 1) % N;
        tick;
        check("post_ack_clear", ack, 0);
        check("post_err_clear", err, 0);
        check("post_active_clear", active, 0);
    endtask

    initial begin
        reset   = 1'b0;
        en      = 1'b0;
        req     = '0;
        data_in = '0;
        mesgul  = 1'b0;
        #3;
        check("rst_ack", ack, 0);
        check("rst_err", err, 0);
        check("rst_baslat", baslat, 0);
        check("rst_active", active, 0);
        check("rst_gnt", gnt_id, 0);
        check("rst_d", D, 0);
        tick;
        tick;
        reset = 1'b1;

        // Single request on requester 1 with a 10-cycle busy period.
        en      = 1'b1;
        data_in = N*DW'($urandom);
        data_in[1*DW +: DW] = 5'b01010;
        req     = 4'b0010;
        run_transfer(1, 10, 1'b0, 1'b1, 1'b0, got);
        check("single_id", got, 1);

        // Timeout on requester 0, then a normal transfer afterwards.
        req = 4'b0001;
        run_transfer(0, 0, 1'b1, 1'b1, 1'b0, got);
        req = 4'b1000;
        run_transfer(2, 3, 1'b0, 1'b1, 1'b0, got);

        // en gating: no grant while en=0.
        en  = 1'b0;
        req = 4'b0100;
        for (int i = 0; i < 4; i++) begin
            tick;
            check("gate_no_active", active, 0);
            check("gate_no_baslat", baslat, 0);
        end
        en = 1'b1;
        run_transfer(1, 4, 1'b0, 1'b0, 1'b1, got);
        for (int i = 0; i < 4; i++) begin
            tick;
            check("gate_after_no_active", active, 0);
            check("gate_after_no_baslat", baslat, 0);
        end

        // Reset during WAIT_DONE.
        en = 1'b1;
        tick;
        check("rst_test_grant", gnt_id, model_pick(req, mptr));
        mesgul = 1'b1;
        tick;
        tick;
        tick;
        #2;
        reset = 1'b0;
        #1;
        check("midrst_active", active, 0);
        check("midrst_gnt", gnt_id, 0);
        check("midrst_d", D, 0);
        check("midrst_ack", ack, 0);
        check("midrst_baslat", baslat, 0);
        mesgul = 1'b0;
        req    = 4'b1111;
        tick;
        reset = 1'b1;
        mptr  = 0;

        // Round robin with all requests held: order 0,1,2,3,0.
        for (int i = 0; i < 5; i++) begin
            run_transfer(1, 2, 1'b0, 1'b0, 1'b0, got);
            order[i] = got;
        end
        check("rr_order0", order[0], 0);
        check("rr_order1", order[1], 1);
        check("rr_order2", order[2], 2);
        check("rr_order3", order[3], 3);
        check("rr_order4", order[4], 0);

        // Randomized transfers against the model.
        for (int t = 0; t < 25; t++) begin
            req     = N'($urandom_range(15, 1));
            data_in = N*DW'($urandom);
            run_transfer($urandom_range(4), $urandom_range(12, 2),
                         ($urandom_range(5) == 0), 1'b1, 1'b0, got);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
